// File: rtl/dsp_sched_pkg.sv
// Shared encodings and default latencies for the DSP issue scoreboard.
package dsp_sched_pkg;

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_MAC  = 2'd1,
    UNIT_SIMD = 2'd2,
    UNIT_LOAD = 2'd3
  } unit_e;

  typedef enum logic [1:0] {
    STALL_NONE = 2'd0,
    STALL_RAW  = 2'd1,
    STALL_WAW  = 2'd2,
    STALL_PORT = 2'd3
  } stall_e;

  localparam int DEF_ALU_LAT    = 1;
  localparam int DEF_MAC_LAT    = 3;
  localparam int DEF_SIMD_LAT   = 2;
  localparam int DEF_MAX_LAT    = 8;
  localparam int DEF_LOAD_DEPTH = 4;

endpackage

// File: rtl/load_tag_fifo.sv
// In-order tag FIFO for outstanding loads: {rd, squash} per entry,
// with a squash-all that marks every queued entry as dead.
module load_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [AW-1:0] push_rd,
  input  logic          push_squash,
  input  logic          pop,
  input  logic          squash_all,
  output logic          full,
  output logic          empty,
  output logic [AW-1:0] head_rd,
  output logic          head_squash
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;
  logic [DEPTH-1:0]         sq_q, sq_d;
  logic [PW-1:0]            wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == CW'(DEPTH));
  assign head_rd     = rd_q[rp_q];
  assign head_squash = sq_q[rp_q];

  always_comb begin
    rd_d  = rd_q;
    sq_d  = sq_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (squash_all) sq_d = '1;
    // a fresh push is never squashed by the same-cycle squash-all
    if (push) begin
      rd_d[wp_q] = push_rd;
      sq_d[wp_q] = push_squash;
      wp_d       = inc(wp_q);
    end
    if (pop) rp_d = inc(rp_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      sq_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      sq_q  <= sq_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dsp_issue_scoreboard.sv
// Per-register issue scoreboard and single-port writeback scheduler.
// Optional counters: define DSP_SCOREBOARD_STATS_EN.
module dsp_issue_scoreboard
  import dsp_sched_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int REG_AW     = 5,
  parameter int ALU_LAT    = DEF_ALU_LAT,
  parameter int MAC_LAT    = DEF_MAC_LAT,
  parameter int SIMD_LAT   = DEF_SIMD_LAT,
  parameter int MAX_LAT    = DEF_MAX_LAT,
  parameter int LOAD_DEPTH = DEF_LOAD_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [1:0]          issue_unit,
  input  logic [REG_AW-1:0]   issue_rd,
  input  logic [REG_AW-1:0]   issue_rs1,
  input  logic [REG_AW-1:0]   issue_rs2,
  input  logic                issue_we,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  output logic                fwd_a,
  output logic                fwd_b,
  output logic [1:0]          stall_cause,
  input  logic                mem_done_valid,
  output logic                mem_done_ready,
  input  logic                flush,
  output logic                wb_valid,
  output logic [REG_AW-1:0]   wb_rd,
  output logic [1:0]          wb_unit,
  output logic [NUM_REGS-1:0] busy_vec
`ifdef DSP_SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_stall
`endif
);
  localparam int LW = $clog2(MAX_LAT + 1);

  if (ALU_LAT < 1 || MAC_LAT < 1 || SIMD_LAT < 1 ||
      ALU_LAT > MAX_LAT || MAC_LAT > MAX_LAT || SIMD_LAT > MAX_LAT) begin : g_bad_lat
    $error("dsp_issue_scoreboard: unit latency outside 1..MAX_LAT");
  end
  if (LOAD_DEPTH < 1 || (LOAD_DEPTH & (LOAD_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dsp_issue_scoreboard: LOAD_DEPTH must be a power of two");
  end

  // slot k of res holds a fixed-latency writeback due k cycles from now; slot 0 drives wb_*
  logic [MAX_LAT:0]             res_q, res_d;
  logic [MAX_LAT:0][REG_AW-1:0] rd_q, rd_d;
  logic [MAX_LAT:0][1:0]        unit_q, unit_d;
  logic [NUM_REGS-1:0]          busy_q, busy_d;

  unit_e         unit;
  logic [LW-1:0] lat;
  logic          is_load, writing, hit1, hit2, raw, waw, port, accept, pop;
  logic          fifo_full, fifo_empty, head_sq;
  logic [REG_AW-1:0] head_rd;
  stall_e        cause;

  assign unit    = unit_e'(issue_unit);
  assign is_load = (unit == UNIT_LOAD);
  assign writing = issue_we && (issue_rd != '0);

  always_comb begin
    case (unit)
      UNIT_ALU:  lat = LW'(ALU_LAT);
      UNIT_MAC:  lat = LW'(MAC_LAT);
      UNIT_SIMD: lat = LW'(SIMD_LAT);
      default:   lat = '0;
    endcase
  end

  // loads yield the port to any fixed-latency writeback in slot 0
  assign mem_done_ready = !fifo_empty && !res_q[0];
  assign pop            = mem_done_valid && mem_done_ready;
  assign wb_valid       = res_q[0] || (pop && !head_sq);
  assign wb_rd          = pop ? head_rd : rd_q[0];
  assign wb_unit        = pop ? UNIT_LOAD : unit_q[0];

  assign hit1  = wb_valid && (wb_rd == issue_rs1);
  assign hit2  = wb_valid && (wb_rd == issue_rs2);
  assign fwd_a = issue_rs1_used && (issue_rs1 != '0) && hit1;
  assign fwd_b = issue_rs2_used && (issue_rs2 != '0) && hit2;
  assign raw   = (issue_rs1_used && busy_q[issue_rs1] && !hit1) ||
                 (issue_rs2_used && busy_q[issue_rs2] && !hit2);
  assign waw   = writing && busy_q[issue_rd] && !(wb_valid && wb_rd == issue_rd);
  assign port  = is_load ? fifo_full : (writing && res_q[lat]);

  always_comb begin
    cause = STALL_NONE;
    if (raw)       cause = STALL_RAW;
    else if (waw)  cause = STALL_WAW;
    else if (port) cause = STALL_PORT;
  end

  assign stall_cause = cause;
  assign issue_ready = !flush && (cause == STALL_NONE);
  assign accept      = issue_valid && issue_ready;
  assign busy_vec    = busy_q;

  always_comb begin
    res_d  = '0;
    rd_d   = '0;
    unit_d = '0;
    for (int k = 0; k < MAX_LAT; k++) begin
      res_d[k]  = res_q[k+1];
      rd_d[k]   = rd_q[k+1];
      unit_d[k] = unit_q[k+1];
    end
    busy_d = busy_q;
    if (res_q[0]) busy_d[rd_q[0]] = 1'b0;
    if (pop && !head_sq) busy_d[head_rd] = 1'b0;
    // a same-cycle set wins over the writeback clear above
    if (accept && writing) begin
      busy_d[issue_rd] = 1'b1;
      if (!is_load) begin
        res_d[lat - LW'(1)]  = 1'b1;
        rd_d[lat - LW'(1)]   = issue_rd;
        unit_d[lat - LW'(1)] = issue_unit;
      end
    end
    if (flush) begin
      res_d  = '0;
      rd_d   = '0;
      unit_d = '0;
      busy_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      rd_q   <= '0;
      unit_q <= '0;
      busy_q <= '0;
    end else begin
      res_q  <= res_d;
      rd_q   <= rd_d;
      unit_q <= unit_d;
      busy_q <= busy_d;
    end
  end

  // non-writing loads still occupy a slot but retire as squashed
  load_tag_fifo #(.DEPTH(LOAD_DEPTH), .AW(REG_AW)) u_ldq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (accept && is_load),
    .push_rd    (issue_rd),
    .push_squash(!writing),
    .pop        (pop),
    .squash_all (flush),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_rd    (head_rd),
    .head_squash(head_sq)
  );

`ifdef DSP_SCOREBOARD_STATS_EN
  logic [31:0] issued_q, stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (accept) issued_q <= issued_q + 32'd1;
      if (issue_valid && !issue_ready) stall_q <= stall_q + 32'd1;
    end
  end
  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule
